// File: rtl/neuron_integrator.sv
// Per-tick neuron controller: fetch, integrate axon spikes, leak,
// hand off to threshold/reset unit, write back and emit spike events.
module neuron_integrator #(
  parameter int NUM_AXONS       = 256,
  parameter int NUM_NEURONS     = 256,
  parameter int POTENTIAL_WIDTH = 9,
  parameter int WEIGHT_WIDTH    = 9,
  parameter int NUM_WEIGHTS     = 4,
  parameter int LEAK_WIDTH      = 9
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        start,
  input  logic [NUM_AXONS-1:0]                        axon_spikes,
  input  logic [NUM_AXONS*$clog2(NUM_WEIGHTS)-1:0]    axon_types,
  output logic                                        param_rd_en,
  output logic [$clog2(NUM_NEURONS)-1:0]              param_addr,
  input  logic [NUM_AXONS-1:0]                        synapses,
  input  logic [POTENTIAL_WIDTH-1:0]                  current_potential,
  input  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0]         weights,
  input  logic [LEAK_WIDTH-1:0]                       leak,
  output logic [POTENTIAL_WIDTH-1:0]                  potential_to_tru,
  input  logic [POTENTIAL_WIDTH-1:0]                  potential_from_tru,
  input  logic                                        spike_from_tru,
  output logic                                        wr_en,
  output logic [$clog2(NUM_NEURONS)-1:0]              wr_addr,
  output logic [POTENTIAL_WIDTH-1:0]                  wr_data,
  output logic                                        spike_valid,
  output logic [$clog2(NUM_NEURONS)-1:0]              spike_neuron,
  input  logic                                        spike_ready,
  output logic                                        busy,
  output logic                                        done
);

  localparam int PW = POTENTIAL_WIDTH;
  localparam int WW = WEIGHT_WIDTH;
  localparam int LW = LEAK_WIDTH;
  localparam int SW = PW + 1;
  localparam int AW = $clog2(NUM_AXONS);
  localparam int NW = $clog2(NUM_NEURONS);
  localparam int TW = $clog2(NUM_WEIGHTS);

  localparam logic [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};
  localparam logic [AW-1:0] A_LAST = AW'(NUM_AXONS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, INTEGRATE, LEAK, FIRE, SEND, DONE
  } state_t;

  state_t state, state_nx;

  logic [NW-1:0]             n;
  logic [AW-1:0]             a;
  logic [PW-1:0]             acc;
  logic [NUM_AXONS-1:0]      spike_reg;
  logic [NUM_AXONS-1:0]      syn_reg;
  logic [NUM_WEIGHTS*WW-1:0] w_reg;
  logic [LW-1:0]             leak_reg;
  logic [NW-1:0]             spk_n;

  logic [TW-1:0] type_sel;
  logic [WW-1:0] w_sel;
  logic          hit;
  logic          n_last;

  function automatic logic [SW-1:0] ext_w(input logic [WW-1:0] v);
    return {{(SW-WW){v[WW-1]}}, v};
  endfunction

  function automatic logic [SW-1:0] ext_l(input logic [LW-1:0] v);
    return {{(SW-LW){v[LW-1]}}, v};
  endfunction

  // One guard bit detects overflow; clamp instead of wrapping.
  function automatic logic [PW-1:0] sat_add(
    input logic [PW-1:0] x,
    input logic [SW-1:0] y
  );
    logic [SW-1:0] s;
    s = {x[PW-1], x} + y;
    if (s[SW-1] != s[SW-2])
      return s[SW-1] ? P_MIN : P_MAX;
    return s[PW-1:0];
  endfunction

  assign type_sel = axon_types[int'(a)*TW +: TW];
  assign w_sel    = w_reg[int'(type_sel)*WW +: WW];
  assign hit      = spike_reg[a] & syn_reg[a];
  assign n_last   = (n == N_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      n         <= '0;
      a         <= '0;
      acc       <= '0;
      spike_reg <= '0;
      syn_reg   <= '0;
      w_reg     <= '0;
      leak_reg  <= '0;
      spk_n     <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            spike_reg <= axon_spikes;
            n         <= '0;
          end
        end
        LOAD: begin
          syn_reg  <= synapses;
          w_reg    <= weights;
          leak_reg <= leak;
          acc      <= current_potential;
          a        <= '0;
        end
        INTEGRATE: begin
          if (hit)
            acc <= sat_add(acc, ext_w(w_sel));
          a <= a + AW'(1);
        end
        LEAK: acc <= sat_add(acc, ext_l(leak_reg));
        FIRE: begin
          if (spike_from_tru)
            spk_n <= n;
          else if (!n_last)
            n <= n + NW'(1);
        end
        SEND: begin
          if (spike_ready && !n_last)
            n <= n + NW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (start) state_nx = FETCH;
      FETCH:     state_nx = LOAD;
      LOAD:      state_nx = INTEGRATE;
      INTEGRATE: if (a == A_LAST) state_nx = LEAK;
      LEAK:      state_nx = FIRE;
      FIRE: begin
        if (spike_from_tru) state_nx = SEND;
        else if (n_last)    state_nx = DONE;
        else                state_nx = FETCH;
      end
      SEND: begin
        if (spike_ready)
          state_nx = n_last ? DONE : FETCH;
      end
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  assign param_rd_en      = (state == FETCH);
  assign param_addr       = n;
  assign potential_to_tru = acc;
  assign wr_en            = (state == FIRE);
  assign wr_addr          = n;
  assign wr_data          = (state == FIRE) ? potential_from_tru : '0;
  assign spike_valid      = (state == SEND);
  assign spike_neuron     = spk_n;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);

endmodule

// File: tb/tb_neuron_integrator.sv
// Scoreboard bench for neuron_integrator on a 4-axon, 2-neuron core
// with a behavioural threshold/reset unit and 1-cycle parameter memory.
module tb_neuron_integrator;

  localparam int NA  = 4;
  localparam int NN  = 2;
  localparam int PW  = 9;
  localparam int WW  = 9;
  localparam int NWT = 4;
  localparam int LW  = 9;
  localparam int TW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [NA-1:0]      axon_spikes = '0;
  logic [NA*TW-1:0]   axon_types = '0;
  logic               param_rd_en;
  logic [0:0]         param_addr;
  logic [NA-1:0]      synapses = '0;
  logic [PW-1:0]      current_potential = '0;
  logic [NWT*WW-1:0]  weights = '0;
  logic [LW-1:0]      leak = '0;
  logic [PW-1:0]      potential_to_tru;
  logic [PW-1:0]      potential_from_tru;
  logic               spike_from_tru;
  logic               wr_en;
  logic [0:0]         wr_addr;
  logic [PW-1:0]      wr_data;
  logic               spike_valid;
  logic [0:0]         spike_neuron;
  logic               spike_ready = 1'b0;
  logic               busy;
  logic               done;

  neuron_integrator #(
    .NUM_AXONS(NA), .NUM_NEURONS(NN), .POTENTIAL_WIDTH(PW),
    .WEIGHT_WIDTH(WW), .NUM_WEIGHTS(NWT), .LEAK_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .axon_spikes(axon_spikes), .axon_types(axon_types),
    .param_rd_en(param_rd_en), .param_addr(param_addr),
    .synapses(synapses), .current_potential(current_potential),
    .weights(weights), .leak(leak),
    .potential_to_tru(potential_to_tru),
    .potential_from_tru(potential_from_tru),
    .spike_from_tru(spike_from_tru),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .spike_valid(spike_valid), .spike_neuron(spike_neuron),
    .spike_ready(spike_ready), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  int thr = 20;
  int rst_val = -5;
  logic [PW-1:0] rst_bits;
  int wt[NWT];
  int ty[NA];
  logic [NA-1:0] spk_cfg, syn_cfg;
  int leak_cfg;
  int pot_cfg[NN];
  logic [NWT*WW-1:0] w_pack;

  int exp_wa[$];
  int exp_wd[$];
  int exp_sn[$];

  // Behavioural threshold/reset unit
  assign rst_bits           = rst_val[PW-1:0];
  assign spike_from_tru     = (int'($signed(potential_to_tru)) >= thr);
  assign potential_from_tru = spike_from_tru ? rst_bits : potential_to_tru;

  // Parameter memory, one-cycle read latency
  always @(posedge clk) begin
    if (param_rd_en) begin
      synapses          <= syn_cfg;
      current_potential <= pot_cfg[param_addr][PW-1:0];
      weights           <= w_pack;
      leak              <= leak_cfg[LW-1:0];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        checks++;
        if (exp_wa.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wr: addr %0d data %0d, none expected",
                   wr_addr, $signed(wr_data));
        end else begin
          int ea, ed;
          ea = exp_wa.pop_front();
          ed = exp_wd.pop_front();
          if (int'(wr_addr) !== ea || int'($signed(wr_data)) !== ed) begin
            errors++;
            $display("FAIL wr: got addr %0d data %0d, expected addr %0d data %0d",
                     wr_addr, $signed(wr_data), ea, ed);
          end
        end
      end
      if (spike_valid && spike_ready) begin
        checks++;
        if (exp_sn.size() == 0) begin
          errors++;
          $display("FAIL unexpected_spike: neuron %0d, none expected",
                   spike_neuron);
        end else begin
          int es;
          es = exp_sn.pop_front();
          if (int'(spike_neuron) !== es) begin
            errors++;
            $display("FAIL spike_neuron: got %0d expected %0d",
                     spike_neuron, es);
          end
        end
      end
    end
  end

  function automatic int clamp(int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  function automatic int model(int pot);
    int acc;
    acc = pot;
    for (int i = 0; i < NA; i++)
      if (spk_cfg[i] && syn_cfg[i])
        acc = clamp(acc + wt[ty[i]]);
    return clamp(acc + leak_cfg);
  endfunction

  task automatic apply_cfg();
    for (int i = 0; i < NWT; i++)
      w_pack[i*WW +: WW] = wt[i][WW-1:0];
    for (int i = 0; i < NA; i++)
      axon_types[i*TW +: TW] = ty[i][TW-1:0];
    axon_spikes = spk_cfg;
  endtask

  task automatic push_expect();
    for (int i = 0; i < NN; i++) begin
      int r;
      r = model(pot_cfg[i]);
      exp_wa.push_back(i);
      if (r >= thr) begin
        exp_wd.push_back(rst_val);
        exp_sn.push_back(i);
      end else begin
        exp_wd.push_back(r);
      end
    end
  endtask

  task automatic set_basic(input int pot);
    wt       = '{3, 0, 0, 0};
    ty       = '{0, 0, 0, 0};
    spk_cfg  = 4'b1111;
    syn_cfg  = 4'b1111;
    leak_cfg = -1;
    pot_cfg  = '{pot, pot};
    thr      = 20;
    apply_cfg();
  endtask

  // Drives one tick and reports what it observed
  task automatic run_tick(
    input  int ready_delay,
    input  int pulse_at,
    output int done_cyc,
    output int rd_cnt,
    output int wr_cnt,
    output int vmin,
    output int vmax,
    output int unstable
  );
    int cyc, vrun, sn;
    rd_cnt = 0; wr_cnt = 0; vmin = 1000; vmax = 0;
    unstable = 0; vrun = 0; sn = 0;
    spike_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 400 && !done) begin
      if (param_rd_en) rd_cnt++;
      if (wr_en) wr_cnt++;
      if (spike_valid) begin
        if (vrun == 0) sn = int'(spike_neuron);
        else if (int'(spike_neuron) != sn) unstable++;
        vrun++;
        spike_ready = (vrun > ready_delay);
      end else begin
        if (vrun > 0) begin
          if (vrun < vmin) vmin = vrun;
          if (vrun > vmax) vmax = vrun;
        end
        vrun = 0;
        spike_ready = 1'b0;
      end
      start = (cyc == pulse_at);
      @(posedge clk); #1;
      cyc++;
    end
    if (vrun > 0) begin
      if (vrun < vmin) vmin = vrun;
      if (vrun > vmax) vmax = vrun;
    end
    start = 1'b0;
    spike_ready = 1'b0;
    done_cyc = done ? cyc : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, wr_en, spike_valid, param_rd_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {busy, done, wr_en, spike_valid, param_rd_en});
    end
    checks++;
    if (potential_to_tru !== '0) begin
      errors++;
      $display("FAIL reset_acc: got %0d expected 0", potential_to_tru);
    end
    checks++;
    if ({wr_data, wr_addr, spike_neuron, param_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {wr_data, wr_addr, spike_neuron, param_addr});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int dc, rd, wc, vmn, vmx, us;
    set_basic(0);
    push_expect();
    run_tick(0, 0, dc, rd, wc, vmn, vmx, us);
    checks++;
    if (dc !== 17) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d expected 17", dc);
    end
    checks++;
    if (rd !== 2 || wc !== 2 || vmx !== 0) begin
      errors++;
      $display("FAIL basic_counts: got rd %0d wr %0d spk %0d expected 2 2 0",
               rd, wc, vmx);
    end
    checks++;
    if (int'($signed(potential_to_tru)) !== 11) begin
      errors++;
      $display("FAIL basic_acc: got %0d expected 11",
               $signed(potential_to_tru));
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done %b busy %b expected 0 0",
               done, busy);
    end
    checks++;
    if (exp_wa.size() !== 0) begin
      errors++;
      $display("FAIL basic_missing_wr: got %0d left expected 0",
               exp_wa.size());
      exp_wa.delete(); exp_wd.delete();
    end
  endtask

  task automatic test_spike();
    int dc, rd, wc, vmn, vmx, us;
    set_basic(10);
    push_expect();
    run_tick(3, 0, dc, rd, wc, vmn, vmx, us);
    checks++;
    if (dc !== 25) begin
      errors++;
      $display("FAIL spike_done_cycle: got %0d expected 25", dc);
    end
    checks++;
    if (vmn !== 4 || vmx !== 4) begin
      errors++;
      $display("FAIL spike_valid_len: got min %0d max %0d expected 4 4",
               vmn, vmx);
    end
    checks++;
    if (us !== 0) begin
      errors++;
      $display("FAIL spike_neuron_stable: got %0d changes expected 0", us);
    end
    checks++;
    if (wc !== 2 || exp_sn.size() !== 0 || exp_wa.size() !== 0) begin
      errors++;
      $display("FAIL spike_events: got wr %0d left spk %0d wr %0d expected 2 0 0",
               wc, exp_sn.size(), exp_wa.size());
      exp_wa.delete(); exp_wd.delete(); exp_sn.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturate();
    int dc, rd, wc, vmn, vmx, us;
    for (int k = 0; k < 2; k++) begin
      int w, e;
      w = (k == 0) ? 200 : -200;
      e = (k == 0) ? 255 : -256;
      set_basic(0);
      wt = '{w, 0, 0, 0};
      leak_cfg = 0;
      thr = 1000;
      apply_cfg();
      push_expect();
      run_tick(0, 0, dc, rd, wc, vmn, vmx, us);
      checks++;
      if (int'($signed(potential_to_tru)) !== e || dc !== 17) begin
        errors++;
        $display("FAIL saturate_%0d: got acc %0d cycle %0d expected %0d 17",
                 k, $signed(potential_to_tru), dc, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mixed();
    int dc, rd, wc, vmn, vmx, us;
    wt       = '{8, 4, 2, 1};
    ty       = '{0, 1, 2, 3};
    spk_cfg  = 4'b0110;
    syn_cfg  = 4'b1010;
    leak_cfg = -2;
    pot_cfg  = '{5, -3};
    thr      = 1000;
    apply_cfg();
    push_expect();
    run_tick(0, 0, dc, rd, wc, vmn, vmx, us);
    checks++;
    if (int'($signed(potential_to_tru)) !== -1) begin
      errors++;
      $display("FAIL mixed_acc: got %0d expected -1",
               $signed(potential_to_tru));
    end
    checks++;
    if (exp_wa.size() !== 0 || dc !== 17) begin
      errors++;
      $display("FAIL mixed_done: got left %0d cycle %0d expected 0 17",
               exp_wa.size(), dc);
      exp_wa.delete(); exp_wd.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_start();
    int dc, rd, wc, vmn, vmx, us, extra;
    set_basic(0);
    push_expect();
    run_tick(0, 5, dc, rd, wc, vmn, vmx, us);
    checks++;
    if (dc !== 17 || rd !== 2) begin
      errors++;
      $display("FAIL busy_start_tick: got cycle %0d rd %0d expected 17 2",
               dc, rd);
    end
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL busy_start_restart: got %0d busy cycles expected 0",
               extra);
    end
  endtask

  task automatic test_reset_mid();
    set_basic(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || int'($signed(potential_to_tru)) !== 3) begin
      errors++;
      $display("FAIL mid_pre: got busy %b acc %0d expected 1 3",
               busy, $signed(potential_to_tru));
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, wr_en, spike_valid, param_rd_en} !== 5'b0 ||
        potential_to_tru !== '0) begin
      errors++;
      $display("FAIL mid_reset: got ctrl %b acc %0d expected 00000 0",
               {busy, done, wr_en, spike_valid, param_rd_en},
               potential_to_tru);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle: got busy %b expected 0", busy);
    end
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_spike();
    test_saturate();
    test_mixed();
    test_busy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
